// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and ALU_Control.
// The addi path (states 10/11) is enabled by defining MC_ADDI_EN.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: state -> datapath control word. Define MC_ADDI_EN
// to give states 10/11 their addi meaning; otherwise they decode to all zeros.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main-control FSM: state register, opcode-driven next state
// and reset gating of all outputs. Define MC_ADDI_EN to support addi.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALU_Op,
    output logic [1:0]         PCSource,
    output logic               InstrDone,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_t state, state_nxt;
    ctrl_t  ctrl, ctrl_g;
    logic   illegal;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        illegal   = 1'b0;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_W'(OP_LW) || Opcode == OP_W'(OP_SW)) state_nxt = S_MEM_ADDR;
                else if (Opcode == OP_W'(OP_R))   state_nxt = S_EXECUTE;
                else if (Opcode == OP_W'(OP_BEQ)) state_nxt = S_BRANCH;
                else if (Opcode == OP_W'(OP_J))   state_nxt = S_JUMP;
`ifdef MC_ADDI_EN
                else if (Opcode == OP_W'(OP_ADDI)) state_nxt = S_ADDI_EXEC;
`endif
                else illegal = 1'b1;
            end
            // A non-memory opcode here can only mean IR was disturbed; abandon safely.
            S_MEM_ADDR: begin
                if (Opcode == OP_W'(OP_SW))      state_nxt = S_MEM_WRITE;
                else if (Opcode == OP_W'(OP_LW)) state_nxt = S_MEM_READ;
                else                             state_nxt = S_FETCH;
            end
            S_MEM_READ: state_nxt = S_MEM_WB;
            S_EXECUTE:  state_nxt = S_R_WB;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Gate combinationally so no strobe escapes during the reset cycle itself.
    assign ctrl_g = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_g.pc_write;
    assign PCWriteCond = ctrl_g.pc_write_cond;
    assign IorD        = ctrl_g.iord;
    assign MemRead     = ctrl_g.mem_read;
    assign MemWrite    = ctrl_g.mem_write;
    assign IRWrite     = ctrl_g.ir_write;
    assign MemtoReg    = ctrl_g.mem_to_reg;
    assign RegDst      = ctrl_g.reg_dst;
    assign RegWrite    = ctrl_g.reg_write;
    assign ALUSrcA     = ctrl_g.alu_src_a;
    assign ALUSrcB     = ctrl_g.alu_src_b;
    assign ALU_Op      = ctrl_g.alu_op;
    assign PCSource    = ctrl_g.pc_source;
    assign InstrDone   = ctrl_g.instr_done;
    assign Illegal     = illegal & ~reset;
    assign State       = reset ? '0 : STATE_W'(state);

endmodule
